cfg_bus_arbiter: RTL and testbench

//  Shares the single config register bus (addr/wdata/wr_en/rd_en/rdata) between
//  N_REQ masters: I2C slave (0), debug UART bridge (1), boot config sequencer (2).

---
 rtl/cfg_bus_pkg.sv | 23 ++
 rtl/cfg_bus_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/cfg_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_bus_pkg.sv
// Shared types and constants for the config-bus arbiter slice.
package cfg_bus_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned GNT_W   = 3;

  typedef logic [7:0]       reg_addr_t;
  typedef logic [7:0]       reg_data_t;
  typedef logic [GNT_W-1:0] gnt_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDATA,
    HOLD
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic gnt_id_t next_ptr(gnt_id_t idx, int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/cfg_bus_arbiter_if.sv
// Requester handshake plus register-bank port of the config-bus arbiter.
interface cfg_bus_arbiter_if
  import cfg_bus_pkg::*;
#(
  parameter int unsigned N_REQ = 3
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_we;
  logic [N_REQ-1:0]   req_lock;
  logic [N_REQ*8-1:0] req_addr;
  logic [N_REQ*8-1:0] req_wdata;
  logic [N_REQ-1:0]   ack;
  reg_data_t          rsp_rdata;
  gnt_id_t            gnt_id;
  logic               busy;
  logic               lock_timeout;
  reg_addr_t          bus_addr;
  reg_data_t          bus_wdata;
  logic               bus_wr_en;
  logic               bus_rd_en;
  reg_data_t          bus_rdata;

  // Requesters and register bank side.
  modport master (
    output req, req_we, req_lock, req_addr, req_wdata, bus_rdata,
    input  ack, rsp_rdata, gnt_id, busy, lock_timeout,
    input  bus_addr, bus_wdata, bus_wr_en, bus_rd_en
  );

  // Arbiter side.
  modport slave (
    input  req, req_we, req_lock, req_addr, req_wdata, bus_rdata,
    output ack, rsp_rdata, gnt_id, busy, lock_timeout,
    output bus_addr, bus_wdata, bus_wr_en, bus_rd_en
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import cfg_bus_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  gnt_id_t          ptr,
  output logic [N_REQ-1:0] gnt,
  output gnt_id_t          idx,
  output logic             valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    // First pass covers [ptr, N_REQ), second pass wraps to [0, ptr).
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!valid && req[k] && (k >= 32'(ptr))) begin
        gnt[k] = 1'b1;
        idx    = GNT_W'(k);
        valid  = 1'b1;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!valid && req[k]) begin
        gnt[k] = 1'b1;
        idx    = GNT_W'(k);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing the config register bus, with optional bus lock.
// Optional forced lock release: define CFG_ARB_LOCK_TIMEOUT_EN.
module cfg_bus_arbiter
  import cfg_bus_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  cfg_bus_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > MAX_REQ || LOCK_TIMEOUT == 0) begin : g_param_check
    $error("cfg_bus_arbiter: unsupported N_REQ or LOCK_TIMEOUT");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] own_q, own_d;
  gnt_id_t          idx_q, idx_d;
  gnt_id_t          ptr_q, ptr_d;
  logic             we_q, we_d;
  logic             lock_q, lock_d;
  reg_addr_t        addr_q, addr_d;
  reg_data_t        wdata_q, wdata_d;
  reg_data_t        rdata_q, rdata_d;

  logic [N_REQ-1:0] rr_gnt;
  gnt_id_t          rr_idx;
  logic             rr_valid;

  logic [N_REQ-1:0] sel;
  logic             sel_we, sel_lock;
  reg_addr_t        sel_addr;
  reg_data_t        sel_wdata;
  logic             owner_req, owner_lock;

  logic [N_REQ-1:0] ack;
  logic             wr_en, rd_en, lock_to;
  logic             load, done, drop;
  logic             timeout_hit;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // In HOLD only the current owner may reissue.
  always_comb begin
    sel       = (state_q == HOLD) ? own_q : rr_gnt;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (sel[k]) begin
        sel_we    = bus.req_we[k];
        sel_lock  = bus.req_lock[k];
        sel_addr  = bus.req_addr[k*8 +: 8];
        sel_wdata = bus.req_wdata[k*8 +: 8];
      end
    end
  end

  assign owner_req  = |(bus.req & own_q);
  assign owner_lock = |(bus.req_lock & own_q);

`ifdef CFG_ARB_LOCK_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == 16'(LOCK_TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == HOLD && !owner_req && owner_lock && !timeout_hit) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    idx_d   = idx_q;
    we_d    = we_q;
    lock_d  = lock_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    ack     = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    lock_to = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          own_d = rr_gnt;
          idx_d = rr_idx;
          load  = 1'b1;
        end
      end
      ISSUE: begin
        wr_en = we_q;
        rd_en = !we_q;
        if (we_q) begin
          ack  = own_q;
          done = 1'b1;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        ack     = own_q;
        rdata_d = bus.bus_rdata;
        done    = 1'b1;
      end
      HOLD: begin
        if (owner_req) begin
          load = 1'b1;
        end else if (!owner_lock) begin
          drop = 1'b1;
        end else if (timeout_hit) begin
          lock_to = 1'b1;
          drop    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      we_d    = sel_we;
      lock_d  = sel_lock;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      state_d = ISSUE;
    end
    if (done && lock_q) begin
      state_d = HOLD;
    end else if (done || drop) begin
      state_d = IDLE;
      ptr_d   = next_ptr(idx_q, N_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      lock_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      lock_q  <= lock_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bank data is registered, so it is passed straight through while acking a read.
  assign bus.rsp_rdata    = (state_q == RDATA) ? bus.bus_rdata : rdata_q;
  assign bus.ack          = ack;
  assign bus.gnt_id       = idx_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.lock_timeout = lock_to;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_wdata    = wdata_q;
  assign bus.bus_wr_en    = wr_en;
  assign bus.bus_rd_en    = rd_en;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Self-checking bench for cfg_bus_arbiter: directed scenarios then randomized traffic
// checked against a transaction-level round-robin model.
module tb_cfg_bus_arbiter;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_bus_arbiter_if #(.N_REQ(N)) bif ();

  cfg_bus_arbiter #(
    .N_REQ        (N),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  // Register bank: registered read, preload port for setup.
  logic [7:0] bank_mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) bank_mem[pl_addr] <= pl_data;
    else if (bif.bus_wr_en) bank_mem[bif.bus_addr] <= bif.bus_wdata;
    if (bif.bus_rd_en) bif.bus_rdata <= bank_mem[bif.bus_addr];
  end

  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input int m, input bit r, input bit we, input bit lk,
                     input logic [7:0] a, input logic [7:0] d);
    bif.req[m]              = r;
    bif.req_we[m]           = we;
    bif.req_lock[m]         = lk;
    bif.req_addr[m*8 +: 8]  = a;
    bif.req_wdata[m*8 +: 8] = d;
  endtask

  task automatic idle_all();
    bif.req       = '0;
    bif.req_we    = '0;
    bif.req_lock  = '0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(bif.ack), 0);
    chk({tag, "_rdata"}, 32'(bif.rsp_rdata), 0);
    chk({tag, "_gnt"}, 32'(bif.gnt_id), 0);
    chk({tag, "_busy"}, 32'(bif.busy), 0);
    chk({tag, "_lockto"}, 32'(bif.lock_timeout), 0);
    chk({tag, "_addr"}, 32'(bif.bus_addr), 0);
    chk({tag, "_wdata"}, 32'(bif.bus_wdata), 0);
    chk({tag, "_strobes"}, 32'({bif.bus_wr_en, bif.bus_rd_en}), 0);
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Spec rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, prev, cnt, ptr_m, rd_pend, issued, done_n;
    bit seen, idle_prev, busy_now, strobe;
    logic [N-1:0] exp_ack, req_smp;
    logic [7:0] rd_exp, d;
    bit act [N];
    bit t_we [N];
    logic [7:0] t_addr [N];
    logic [7:0] t_wd [N];

    idle_all();
    bif.bus_rdata = '0;
    // Preload bank and model with identical contents while in reset.
    for (int a = 0; a < 256; a++) begin
      d = (a == 8'hFE) ? 8'h05 : 8'($urandom);
      pl_we = 1'b1; pl_addr = 8'(a); pl_data = d; ref_mem[a] = d;
      @(negedge clk);
    end
    pl_we = 1'b0;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write from master 0.
    set(0, 1, 1, 0, 8'h01, 8'h3C);
    @(negedge clk);
    chk("t1_wr_en", 32'(bif.bus_wr_en), 1);
    chk("t1_rd_en", 32'(bif.bus_rd_en), 0);
    chk("t1_addr", 32'(bif.bus_addr), 32'h01);
    chk("t1_wdata", 32'(bif.bus_wdata), 32'h3C);
    chk("t1_ack", 32'(bif.ack), 32'b001);
    ref_mem[8'h01] = 8'h3C;
    set(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t1_one_strobe", 32'(bif.bus_wr_en), 0);
    chk("t1_ack_pulse", 32'(bif.ack), 0);
    chk("t1_addr_hold", 32'(bif.bus_addr), 32'h01);
    chk("t1_idle", 32'(bif.busy), 0);

    // 2: read from master 1, bank returns 0x05.
    set(1, 1, 0, 0, 8'hFE, 8'h00);
    @(negedge clk);
    chk("t2_rd_en", 32'(bif.bus_rd_en), 1);
    chk("t2_wr_en", 32'(bif.bus_wr_en), 0);
    chk("t2_addr", 32'(bif.bus_addr), 32'hFE);
    chk("t2_no_early_ack", 32'(bif.ack), 0);
    @(negedge clk);
    chk("t2_ack", 32'(bif.ack), 32'b010);
    chk("t2_rdata", 32'(bif.rsp_rdata), 32'h05);
    chk("t2_rd_pulse", 32'(bif.bus_rd_en), 0);
    set(1, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t2_ack_pulse", 32'(bif.ack), 0);
    chk("t2_rdata_hold", 32'(bif.rsp_rdata), 32'h05);

    // 3: all masters stream writes, rotation from a fresh pointer.
    do_reset();
    for (int m = 0; m < N; m++) set(m, 1, 1, 0, 8'(8'h10 + m), 8'(8'hA0 + m));
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!bif.bus_wr_en && w < 5);
      chk("t3_strobe", 32'(bif.bus_wr_en), 1);
      chk("t3_order", 32'(bif.gnt_id), 32'(k % 3));
      chk("t3_addr", 32'(bif.bus_addr), 32'(8'h10 + k % 3));
      chk("t3_ack", 32'(bif.ack), 32'(1 << (k % 3)));
      chk("t3_no_repeat", 32'(int'(bif.gnt_id) != prev), 1);
      prev = int'(bif.gnt_id);
    end
    for (int m = 0; m < N; m++) ref_mem[8'h10 + m] = 8'(8'hA0 + m);
    idle_all();
    @(negedge clk);

    // 4: locked pair from master 0 with master 1 waiting.
    set(0, 1, 1, 1, 8'h02, 8'h11);
    set(1, 1, 1, 0, 8'h77, 8'h22);
    @(negedge clk);
    chk("t4_first_addr", 32'(bif.bus_addr), 32'h02);
    chk("t4_first_ack", 32'(bif.ack), 32'b001);
    set(0, 1, 1, 0, 8'h03, 8'h33);
    @(negedge clk);
    chk("t4_hold_busy", 32'(bif.busy), 1);
    chk("t4_hold_gnt", 32'(bif.gnt_id), 0);
    chk("t4_hold_quiet", 32'({bif.bus_wr_en, bif.bus_rd_en}), 0);
    @(negedge clk);
    chk("t4_second_addr", 32'(bif.bus_addr), 32'h03);
    chk("t4_second_ack", 32'(bif.ack), 32'b001);
    set(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4_release_idle", 32'(bif.busy), 0);
    @(negedge clk);
    chk("t4_m1_addr", 32'(bif.bus_addr), 32'h77);
    chk("t4_m1_ack", 32'(bif.ack), 32'b010);
    ref_mem[8'h02] = 8'h11; ref_mem[8'h03] = 8'h33; ref_mem[8'h77] = 8'h22;
    idle_all();
    @(negedge clk);

    // 5: master 0 locks then idles while master 1 waits.
    set(0, 1, 1, 1, 8'h20, 8'h55);
    set(1, 1, 1, 0, 8'h21, 8'h66);
    @(negedge clk);
    chk("t5_lock_gnt", 32'(bif.gnt_id), 0);
    chk("t5_lock_ack", 32'(bif.ack), 32'b001);
    set(0, 0, 1, 1, 8'h20, 8'h55);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bif.lock_timeout) seen = 1'b1;
    end
`ifdef CFG_ARB_LOCK_TIMEOUT_EN
    chk("t5_timeout_seen", 32'(seen), 1);
    chk("t5_timeout_cycle", 32'(cnt), 16);
    set(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_pulse_width", 32'(bif.lock_timeout), 0);
`else
    chk("t5_no_timeout", 32'(seen), 0);
    chk("t5_still_hold", 32'(bif.busy), 1);
    chk("t5_still_owner", 32'(bif.gnt_id), 0);
    set(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
`endif
    chk("t5_idle", 32'(bif.busy), 0);
    @(negedge clk);
    chk("t5_m1_gnt", 32'(bif.gnt_id), 1);
    chk("t5_m1_ack", 32'(bif.ack), 32'b010);
    ref_mem[8'h20] = 8'h55; ref_mem[8'h21] = 8'h66;
    idle_all();
    @(negedge clk);

    // 6: reset during the data phase of a read, then a tie from a fresh pointer.
    set(1, 1, 0, 0, 8'hFE, 8'h00);
    @(negedge clk);
    chk("t6_rd_en", 32'(bif.bus_rd_en), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t6_abort");
    idle_all();
    @(negedge clk);
    chk("t6_no_ack", 32'(bif.ack), 0);
    rst_n = 1'b1;
    set(2, 1, 1, 0, 8'h32, 8'hC2);
    set(0, 1, 1, 0, 8'h30, 8'hC0);
    @(negedge clk);
    chk("t6_first_gnt", 32'(bif.gnt_id), 0);
    chk("t6_first_ack", 32'(bif.ack), 32'b001);
    set(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t6_second_gnt", 32'(bif.gnt_id), 2);
    chk("t6_second_addr", 32'(bif.bus_addr), 32'h32);
    ref_mem[8'h30] = 8'hC0; ref_mem[8'h32] = 8'hC2;
    idle_all();

    // Randomized traffic against the transaction-level model.
    do_reset();
    ptr_m = 0; rd_pend = -1; issued = 0; done_n = 0;
    idle_prev = 1'b1; req_smp = '0; rd_exp = '0;
    for (int m = 0; m < N; m++) begin
      act[m] = 1'b0; t_we[m] = 1'b0; t_addr[m] = '0; t_wd[m] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      strobe   = bif.bus_wr_en | bif.bus_rd_en;
      busy_now = strobe;
      exp_ack  = '0;
      if (rd_pend >= 0) begin
        exp_ack[rd_pend] = 1'b1;
        chk("rand_rdata", 32'(bif.rsp_rdata), 32'(rd_exp));
        act[rd_pend] = 1'b0;
        done_n++;
        ptr_m = (rd_pend + 1) % N;
        rd_pend = -1;
        busy_now = 1'b1;
      end
      chk("rand_strobe", 32'(strobe), 32'(idle_prev && (req_smp != '0)));
      if (strobe) begin
        chk("rand_one_strobe", 32'(bif.bus_wr_en & bif.bus_rd_en), 0);
        w = pick(req_smp, ptr_m);
        if (w >= 0) begin
          chk("rand_gnt", 32'(bif.gnt_id), 32'(w));
          chk("rand_addr", 32'(bif.bus_addr), 32'(t_addr[w]));
          chk("rand_dir", 32'(bif.bus_wr_en), 32'(t_we[w]));
          if (t_we[w]) begin
            chk("rand_wdata", 32'(bif.bus_wdata), 32'(t_wd[w]));
            ref_mem[t_addr[w]] = t_wd[w];
            exp_ack[w] = 1'b1;
            act[w] = 1'b0;
            done_n++;
            ptr_m = (w + 1) % N;
          end else begin
            rd_pend = w;
            rd_exp = ref_mem[t_addr[w]];
          end
        end
      end
      chk("rand_ack", 32'(bif.ack), 32'(exp_ack));
      if (cyc < 360) begin
        for (int m = 0; m < N; m++) begin
          if (!act[m] && $urandom_range(0, 1) == 1) begin
            act[m]    = 1'b1;
            t_we[m]   = 1'($urandom_range(0, 1));
            t_addr[m] = 8'($urandom);
            t_wd[m]   = 8'($urandom);
            issued++;
          end
        end
      end
      for (int m = 0; m < N; m++) begin
        set(m, act[m], t_we[m], 1'b0, t_addr[m], t_wd[m]);
        req_smp[m] = act[m];
      end
      idle_prev = !busy_now;
    end
    chk("rand_drain", 32'(done_n), 32'(issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
